// File: rtl/fifo_multicanal.sv
// N-channel FIFO bank: independent per-channel pointers, counts, flags and sticky errors over one shared storage block.
// Optional per-channel occupancy output is enabled by defining FIFO_OCCUPANCY_EN.
module fifo_multicanal #(
  parameter int N_CHANNELS             = 4,
  parameter int FIFO_DEPTH             = 8,
  parameter int FIFO_WORD_SIZE         = 10,
  parameter int ALMOST_EMPTY_THRESHOLD = 2,
  parameter int ALMOST_FULL_THRESHOLD  = 6,
  localparam int FIFO_PTR_SIZE = $clog2(FIFO_DEPTH),
  localparam int CH_SIZE       = $clog2(N_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      wr_en,
  input  logic [CH_SIZE-1:0]        wr_ch,
  input  logic                      rd_en,
  input  logic [CH_SIZE-1:0]        rd_ch,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  output logic [N_CHANNELS-1:0]     empty_flag,
  output logic [N_CHANNELS-1:0]     full_flag,
  output logic [N_CHANNELS-1:0]     almost_empty_flag,
  output logic [N_CHANNELS-1:0]     almost_full_flag,
  output logic [N_CHANNELS-1:0]     error_flag
`ifdef FIFO_OCCUPANCY_EN
  ,
  output logic [N_CHANNELS*(FIFO_PTR_SIZE+1)-1:0] occupancy
`endif
);

  localparam int CNT_W = FIFO_PTR_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_THRESHOLD);
  localparam logic [FIFO_PTR_SIZE-1:0] PTR_ONE = FIFO_PTR_SIZE'(1);

  logic [FIFO_WORD_SIZE-1:0] mem [N_CHANNELS][FIFO_DEPTH];
  logic [FIFO_PTR_SIZE-1:0]  wr_ptr [N_CHANNELS];
  logic [FIFO_PTR_SIZE-1:0]  rd_ptr [N_CHANNELS];
  logic [CNT_W-1:0]          count  [N_CHANNELS];

  logic                  wr_accept;
  logic                  rd_accept;
  logic [N_CHANNELS-1:0] inc;
  logic [N_CHANNELS-1:0] dec;

  always_comb begin
    empty_flag        = '0;
    full_flag         = '0;
    almost_empty_flag = '0;
    almost_full_flag  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      empty_flag[c]        = (count[c] == CNT_ZERO);
      full_flag[c]         = (count[c] == CNT_FULL);
      almost_empty_flag[c] = (count[c] <= CNT_AE);
      almost_full_flag[c]  = (count[c] >= CNT_AF);
    end
  end

  // A full channel still accepts a write when the same edge reads a word out of it.
  assign rd_accept = rd_en & ~empty_flag[rd_ch];
  assign wr_accept = wr_en & (~full_flag[wr_ch] | (rd_accept & (rd_ch == wr_ch)));

  always_comb begin
    inc = '0;
    dec = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      inc[c] = wr_accept & (wr_ch == CH_SIZE'(c));
      dec[c] = rd_accept & (rd_ch == CH_SIZE'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem[wr_ch][wr_ptr[wr_ch]] <= data_in;
  end

  // Output handshake: valid_out is a one-cycle qualifier with no ready; data_out carries the
  // word of the read accepted on the previous edge, and holds its value when valid_out is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      data_out   <= '0;
      valid_out  <= 1'b0;
      error_flag <= '0;
    end else begin
      valid_out <= rd_accept;
      if (rd_accept) data_out <= mem[rd_ch][rd_ptr[rd_ch]];
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (inc[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (dec[c]) rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        if (inc[c] && !dec[c])      count[c] <= count[c] + CNT_ONE;
        else if (dec[c] && !inc[c]) count[c] <= count[c] - CNT_ONE;
      end
      if (rd_en && !rd_accept) error_flag[rd_ch] <= 1'b1;
      if (wr_en && !wr_accept) error_flag[wr_ch] <= 1'b1;
    end
  end

`ifdef FIFO_OCCUPANCY_EN
  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_occ
    assign occupancy[g*CNT_W +: CNT_W] = count[g];
  end
`endif

endmodule
